// File: rtl/lpc_pkg.sv
// Shared constants, FIFO entry type and Hamming coefficient generator for the LPC window fetch.
// The coefficient table is only instantiated when LPC_HAMMING_EN is defined.
package lpc_pkg;

  localparam int LPC_WIN_LEN    = 240;
  localparam int LPC_FIFO_DEPTH = 4;
  localparam int LPC_Q15_W      = 16;

  localparam logic [7:0] LPC_LAST_IDX = 8'(LPC_WIN_LEN - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  typedef struct packed {
    logic                 last;
    logic [LPC_Q15_W-1:0] data;
  } win_entry_t;

  localparam longint ONE_Q30 = 64'sd1 << 30;
  localparam longint PI_Q30  = 64'sd3373259426;

  // G.729 analysis window: Hamming half over 0..199, quarter cosine over 200..239.
  // Evaluated only at elaboration to fill the ROM; fixed-point Taylor series in Q30.
  function automatic logic [15:0] hamwin_coef(input int n);
    longint num;
    longint den;
    longint x;
    longint x2;
    longint term;
    longint c;
    longint v;
    logic   neg;
    if (n < 200) begin
      num = longint'(2 * n);
      den = 64'sd399;
    end else begin
      num = longint'(2 * (n - 200));
      den = 64'sd159;
    end
    neg = 1'b0;
    if (2 * num > den) begin
      neg = 1'b1;
      num = den - num;
    end
    x    = (PI_Q30 * num) / den;
    x2   = (x * x) >>> 30;
    term = ONE_Q30;
    c    = ONE_Q30;
    for (int k = 1; k <= 8; k++) begin
      term = -((term * x2) >>> 30) / longint'((2 * k - 1) * (2 * k));
      c    = c + term;
    end
    if (neg) c = -c;
    if (n < 200) v = (64'sd54 * ONE_Q30 - 64'sd46 * c) / 64'sd100;
    else         v = c;
    v = (v + 64'sd16384) >>> 15;
    if (v > 64'sd32767) v = 64'sd32767;
    return 16'(v);
  endfunction

endpackage

// File: rtl/lpc_hamwindow_rom.sv
// 240x16 registered-output ROM holding the G.729 hamwindow table (w[0] = 2621).
// Instantiated by lpc_window_fetch only when LPC_HAMMING_EN is defined.
module lpc_hamwindow_rom
  import lpc_pkg::*;
(
  input  logic        clock,
  input  logic [7:0]  addr,
  output logic [15:0] coef
);

  logic [15:0] rom_table [LPC_WIN_LEN];
  logic [15:0] coef_reg;

  for (genvar gi = 0; gi < LPC_WIN_LEN; gi++) begin : g_rom
    assign rom_table[gi] = hamwin_coef(gi);
  end

  always_ff @(posedge clock) begin
    coef_reg <= rom_table[addr];
  end

  assign coef = coef_reg;

endmodule

// File: rtl/lpc_window_fetch.sv
// Fetches a 240-sample LPC window from sample memory, optionally applies the Hamming window
// (macro LPC_HAMMING_EN), and streams it through a 4-entry show-ahead FIFO with valid/ready.
module lpc_window_fetch
  import lpc_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 frame_done,
  input  logic [LPC_Q15_W-1:0] mem_sample,
  output logic [7:0]           out_count,
  output logic [LPC_Q15_W-1:0] win_sample,
  output logic                 win_valid,
  input  logic                 win_ready,
  output logic                 win_last,
  output logic                 busy,
  output logic                 overrun
);

  logic [1:0]           state_reg;
  logic [7:0]           out_count_reg;
  logic                 pending_reg;
  logic                 overrun_reg;
  logic                 inflight_reg;
  logic                 inflight_last_reg;
  logic [1:0]           wr_ptr_reg;
  logic [1:0]           rd_ptr_reg;
  logic [2:0]           fill_reg;
  win_entry_t           fifo_mem [LPC_FIFO_DEPTH];
  win_entry_t           head;
  logic [LPC_Q15_W-1:0] product;
  logic                 head_valid;
  logic                 issue;
  logic                 push;
  logic                 pop;
  logic                 at_last;
  logic                 start;
  logic                 last_xfer;

  assign head_valid = (fill_reg != 3'd0);
  assign head       = fifo_mem[rd_ptr_reg];
  assign pop        = head_valid && win_ready;
  assign push       = inflight_reg;
  // Reads still in flight reserve a FIFO slot so a stalled consumer can never overflow it.
  assign issue      = (state_reg == ST_FETCH) &&
                      ((fill_reg + {2'b00, inflight_reg}) < 3'(LPC_FIFO_DEPTH));
  assign at_last    = (out_count_reg == LPC_LAST_IDX);
  assign start      = (state_reg == ST_IDLE) && (frame_done || pending_reg);
  assign last_xfer  = (state_reg == ST_DRAIN) && pop && head.last;

`ifdef LPC_HAMMING_EN
  logic [15:0] coef;

  // ROM output for address n lines up with the memory's sample n in the following cycle.
  lpc_hamwindow_rom u_rom (
    .clock (clock),
    .addr  (out_count_reg),
    .coef  (coef)
  );

  assign product = 16'(($signed(mem_sample) * $signed(coef) + 32'sd16384) >>> 15);
`else
  assign product = mem_sample;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg         <= ST_IDLE;
      out_count_reg     <= 8'd0;
      pending_reg       <= 1'b0;
      overrun_reg       <= 1'b0;
      inflight_reg      <= 1'b0;
      inflight_last_reg <= 1'b0;
      wr_ptr_reg        <= 2'd0;
      rd_ptr_reg        <= 2'd0;
      fill_reg          <= 3'd0;
    end else begin
      case (state_reg)
        ST_IDLE:  if (start) state_reg <= ST_FETCH;
        ST_FETCH: if (issue && at_last) state_reg <= ST_DRAIN;
        ST_DRAIN: if (last_xfer) state_reg <= ST_IDLE;
        default:  state_reg <= ST_IDLE;
      endcase

      if (issue) out_count_reg <= at_last ? 8'd0 : out_count_reg + 8'd1;
      inflight_reg      <= issue;
      inflight_last_reg <= issue && at_last;

      if (push) wr_ptr_reg <= wr_ptr_reg + 2'd1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 2'd1;
      fill_reg <= fill_reg + {2'b00, push} - {2'b00, pop};

      // One start may be queued behind the running window; anything beyond that is dropped.
      if (start) begin
        pending_reg <= 1'b0;
        if (frame_done && pending_reg) overrun_reg <= 1'b1;
      end else if (frame_done && (state_reg != ST_IDLE)) begin
        if (pending_reg) overrun_reg <= 1'b1;
        else             pending_reg <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr_reg] <= '{last: inflight_last_reg, data: product};
  end

  assign out_count  = out_count_reg;
  assign win_valid  = head_valid;
  assign win_sample = head_valid ? head.data : '0;
  assign win_last   = head_valid && head.last;
  assign busy       = (state_reg != ST_IDLE);
  assign overrun    = overrun_reg;

endmodule

// File: tb/tb_lpc_window_fetch.sv
// Directed bench for lpc_window_fetch: memory model plus a scoreboard of expected window samples.
// Expectations follow LPC_HAMMING_EN when it is defined for the build.
module tb_lpc_window_fetch;

  logic        clock = 1'b0;
  logic        reset;
  logic        frame_done;
  logic [15:0] mem_sample;
  logic [7:0]  out_count;
  logic [15:0] win_sample;
  logic        win_valid;
  logic        win_ready;
  logic        win_last;
  logic        busy;
  logic        overrun;

  lpc_window_fetch dut (
    .clock      (clock),
    .reset      (reset),
    .frame_done (frame_done),
    .mem_sample (mem_sample),
    .out_count  (out_count),
    .win_sample (win_sample),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .win_last   (win_last),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          idx;
    logic [15:0] data;
    logic        last;
  } exp_t;

  exp_t        sb [$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic        mem_index_mode = 1'b0;
  logic [15:0] mem_const = 16'h0000;
  int          frame_cyc = 0;
  int          first_valid_cyc = 0;
  int          first_xfer_cyc = 0;
  int          last_xfer_cyc = 0;
  int          win_gap = 0;
  int          xfer_count = 0;
  int          last_idx = -1;
  logic        seen_valid = 1'b0;
  logic        hold_pending = 1'b0;
  logic [15:0] held_sample = 16'h0000;
  logic [15:0] first_sample = 16'h0000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] mem_model(input logic [7:0] a);
    return mem_index_mode ? {8'h00, a} : mem_const;
  endfunction

  function automatic logic [15:0] exp_sample(input int n);
    logic [15:0] m;
    m = mem_model(8'(n));
`ifdef LPC_HAMMING_EN
    begin
      real    w;
      int     wi;
      longint p;
      if (n < 200) w = 0.54 - 0.46 * $cos(2.0 * 3.14159265358979 * n / 399.0);
      else         w = $cos(2.0 * 3.14159265358979 * (n - 200) / 159.0);
      wi = $rtoi(w * 32768.0 + 0.5);
      if (wi > 32767) wi = 32767;
      p = longint'($signed(m)) * longint'(wi) + 64'sd16384;
      return 16'(p >>> 15);
    end
`else
    return m;
`endif
  endfunction

  task automatic check_sample(input string tag, input logic [15:0] obs, input logic [15:0] expv);
`ifdef LPC_HAMMING_EN
    int d;
    d = int'($signed(obs)) - int'($signed(expv));
    if (d < 0) d = -d;
    checks++;
    assert (d <= 2) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
`else
    check(tag, 32'(obs), 32'(expv));
`endif
  endtask

  task automatic push_window();
    for (int i = 0; i < 240; i++) sb.push_back('{idx: i, data: exp_sample(i), last: (i == 239)});
  endtask

  // One clock: observe the current cycle, then advance and drive the memory response.
  task automatic tick();
    logic [7:0] addr;
    exp_t       e;
    addr = out_count;
    if (hold_pending) begin
      check("stall_valid", 32'(win_valid), 32'd1);
      check("stall_stable", 32'(win_sample), 32'(held_sample));
    end
    check("out_count_max", 32'(out_count <= 8'd239), 32'd1);
    if (!busy) check("idle_count", 32'(out_count), 32'd0);
    if (win_valid && !seen_valid) begin
      seen_valid      = 1'b1;
      first_valid_cyc = cyc;
    end
    if (win_valid && win_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_xfer", 32'(win_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        check_sample($sformatf("sample[%0d]", e.idx), win_sample, e.data);
        check($sformatf("last[%0d]", e.idx), 32'(win_last), 32'(e.last));
        if (e.idx == 0) begin
          first_sample   = win_sample;
          win_gap        = cyc - last_xfer_cyc;
          first_xfer_cyc = cyc;
        end
        if (e.last) last_xfer_cyc = cyc;
        last_idx = e.idx;
        xfer_count++;
      end
    end
    hold_pending = win_valid && !win_ready;
    held_sample  = win_sample;
    @(posedge clock);
    #1;
    mem_sample = mem_model(addr);
    cyc++;
  endtask

  task automatic pulse_frame(input logic push_it);
    frame_done = 1'b1;
    frame_cyc  = cyc;
    if (push_it) push_window();
    tick();
    frame_done = 1'b0;
  endtask

  task automatic run_until_empty(input int budget, input logic toggle);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      win_ready = toggle ? ~win_ready : 1'b1;
      tick();
      n++;
    end
    win_ready = 1'b1;
    check("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    reset      = 1'b1;
    frame_done = 1'b0;
    win_ready  = 1'b1;
    mem_sample = 16'h0000;
    repeat (3) @(posedge clock);
    #1;
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_win_valid", 32'(win_valid), 32'd0);
    check("rst_win_sample", 32'(win_sample), 32'd0);
    check("rst_win_last", 32'(win_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    reset = 1'b0;
    tick();

    // Constant 0x4000 window, consumer always ready.
    mem_index_mode = 1'b0;
    mem_const      = 16'h4000;
    seen_valid     = 1'b0;
    xfer_count     = 0;
    pulse_frame(1'b1);
    run_until_empty(400, 1'b0);
    check("a_latency", 32'(first_valid_cyc - frame_cyc), 32'd3);
`ifdef LPC_HAMMING_EN
    check("a_first_sample", 32'(first_sample), 32'h051F);
`else
    check("a_first_sample", 32'(first_sample), 32'h4000);
`endif
    check("a_xfers", 32'(xfer_count), 32'd240);
    check("a_back_to_back", 32'(last_xfer_cyc - first_xfer_cyc), 32'd239);
    tick();
    check("a_busy_done", 32'(busy), 32'd0);

    // Index-valued samples with a 1-0-1-0 consumer.
    mem_index_mode = 1'b1;
    xfer_count     = 0;
    pulse_frame(1'b1);
    run_until_empty(1200, 1'b1);
    check("b_xfers", 32'(xfer_count), 32'd240);
    check("b_last_idx", 32'(last_idx), 32'd239);

    // Second frame_done queues a window, the third is dropped as an overrun.
    xfer_count = 0;
    pulse_frame(1'b1);
    repeat (20) tick();
    pulse_frame(1'b1);
    check("c_no_overrun_yet", 32'(overrun), 32'd0);
    repeat (5) tick();
    pulse_frame(1'b0);
    check("c_overrun_set", 32'(overrun), 32'd1);
    run_until_empty(1200, 1'b0);
    check("c_xfers", 32'(xfer_count), 32'd480);
    check("c_pending_gap", 32'(win_gap), 32'd4);
    repeat (10) tick();
    check("c_busy_done", 32'(busy), 32'd0);
    check("c_idle_valid", 32'(win_valid), 32'd0);
    check("c_overrun_sticky", 32'(overrun), 32'd1);

    // Reset in the middle of a window.
    last_idx = -1;
    pulse_frame(1'b1);
    for (int n = 0; n < 400 && last_idx != 100; n++) tick();
    check("d_reach_idx100", 32'(last_idx), 32'd100);
    reset = 1'b1;
    tick();
    sb.delete();
    check("d_rst_out_count", 32'(out_count), 32'd0);
    check("d_rst_win_valid", 32'(win_valid), 32'd0);
    check("d_rst_win_sample", 32'(win_sample), 32'd0);
    check("d_rst_win_last", 32'(win_last), 32'd0);
    check("d_rst_busy", 32'(busy), 32'd0);
    check("d_rst_overrun", 32'(overrun), 32'd0);
    reset = 1'b0;
    for (int n = 0; n < 30; n++) begin
      tick();
      check("d_no_output", 32'(win_valid), 32'd0);
    end

    // Full-scale negative sample.
    mem_index_mode = 1'b0;
    mem_const      = 16'h8000;
    seen_valid     = 1'b0;
    xfer_count     = 0;
    pulse_frame(1'b1);
    run_until_empty(400, 1'b0);
    check("e_latency", 32'(first_valid_cyc - frame_cyc), 32'd3);
`ifdef LPC_HAMMING_EN
    check("e_first_sample", 32'(first_sample), 32'hF5C3);
`else
    check("e_first_sample", 32'(first_sample), 32'h8000);
`endif
    check("e_xfers", 32'(xfer_count), 32'd240);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
